// File: rtl/ddc_pkg.sv
// Shared constants and state encoding for the 4-lane DDC chain
// (fifo4 -> delay -> oscillator/mixer -> FIR).
package ddc_pkg;

  localparam int unsigned DEF_PINC_W     = 32;
  localparam int unsigned DEF_LVL_W      = 6;
  localparam int unsigned DEF_FILL_LEVEL = 16;
  localparam int unsigned DEF_PIPE_LAT   = 14;
  localparam int unsigned DEF_FIR_LAT    = 64;
  localparam int unsigned DEF_CNT_W      = 8;

  // Status encoding exported on state_o; values are visible to software.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILL   = 3'd1,
    ST_PRIME  = 3'd2,
    ST_SETTLE = 3'd3,
    ST_RUN    = 3'd4,
    ST_RETUNE = 3'd5,
    ST_FLUSH  = 3'd6
  } ddc_state_t;

  // Cycles from the first valid sample into the oscillator until the FIR
  // output is trustworthy.
  function automatic int unsigned blank_cycles(input int unsigned pipe_lat,
                                               input int unsigned fir_lat);
    return pipe_lat + fir_lat;
  endfunction

endpackage

// File: rtl/ddc_ctrl_if.sv
// Configuration handshake carrying a new NCO phase increment.
interface ddc_ctrl_if
  import ddc_pkg::*;
#(
  parameter int unsigned PINC_W = DEF_PINC_W
) ();

  logic              cfg_valid_i;
  logic [PINC_W-1:0] cfg_pinc_i;
  logic              cfg_ready_o;

  // Host side offering configurations
  modport master (
    output cfg_valid_i,
    output cfg_pinc_i,
    input  cfg_ready_o
  );

  // Sequencer side accepting configurations
  modport slave (
    input  cfg_valid_i,
    input  cfg_pinc_i,
    output cfg_ready_o
  );

endinterface

// File: rtl/ddc_settle_cnt.sv
// Loadable, non-wrapping down-counter timing the pipeline and FIR flushes.
module ddc_settle_cnt
  import ddc_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] value_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;

  // Load has priority; otherwise count down and park at zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign value_o = cnt_q;
  assign zero_o  = (cnt_q == '0);

endmodule

// File: rtl/ddc_ctrl.sv
// Start-up / retune sequencer for the DDC: gates FIFO reads once filled,
// loads NCO increments at safe points and blanks the FIR output until the
// pipeline has flushed; FIFO errors trigger a flush and restart.
module ddc_ctrl
  import ddc_pkg::*;
#(
  parameter int unsigned PINC_W     = DEF_PINC_W,
  parameter int unsigned LVL_W      = DEF_LVL_W,
  parameter int unsigned FILL_LEVEL = DEF_FILL_LEVEL,
  parameter int unsigned PIPE_LAT   = DEF_PIPE_LAT,
  parameter int unsigned FIR_LAT    = DEF_FIR_LAT,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  ddc_ctrl_if.slave         cfg,
  input  logic [LVL_W-1:0]  fifo_level_i,
  input  logic              fifo_err_i,
  output logic              fifo_rd_en_o,
  output logic              fifo_flush_o,
  output logic              osc_valid_o,
  output logic [PINC_W-1:0] pinc_o,
  output logic              pinc_load_o,
  output logic              out_valid_o,
  output logic [2:0]        state_o
);

  localparam logic [LVL_W-1:0] FILL_LVL  = LVL_W'(FILL_LEVEL);
  localparam logic [CNT_W-1:0] PRIME_LD  = CNT_W'(PIPE_LAT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(FIR_LAT - 1);
  localparam logic [CNT_W-1:0] RETUNE_LD = CNT_W'(blank_cycles(PIPE_LAT, FIR_LAT) - 1);

  ddc_state_t        state_q, state_d;
  logic              rd_en_q;
  logic              flush_q;
  logic              osc_valid_q;
  logic              out_valid_q;
  logic [PINC_W-1:0] pinc_q;
  logic              pinc_load_q;
  logic [PINC_W-1:0] pend_q;
  logic              pend_vld_q;

  logic              cfg_ready;
  logic              cfg_acc;
  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_load_val;
  logic [CNT_W-1:0]  cnt_value;
  logic              cnt_zero;
  logic              cnt_unused;

  ddc_settle_cnt #(
    .CNT_W (CNT_W)
  ) u_settle_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .value_o    (cnt_value),
    .zero_o     (cnt_zero)
  );

  // The count itself is status-only; sequencing keys off the zero flag.
  assign cnt_unused = ^cnt_value;

  // Configs are taken only where a new increment cannot disturb a flush.
  assign cfg_ready = !pend_vld_q &&
                     ((state_q == ST_IDLE) || (state_q == ST_FILL) || (state_q == ST_RUN));
  assign cfg_acc   = cfg.cfg_valid_i && cfg_ready;

  // Next state: FIFO error beats enable drop beats normal sequencing.
  // FLUSH itself ignores the error: the sticky flag is still set during the
  // flush pulse, and re-entering would stretch the pulse.
  always_comb begin
    state_d = state_q;
    if (fifo_err_i && (state_q != ST_IDLE) && (state_q != ST_FLUSH)) begin
      state_d = ST_FLUSH;
    end else if (!enable_i) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:   state_d = ST_FILL;
        ST_FILL:   if (fifo_level_i >= FILL_LVL) state_d = ST_PRIME;
        ST_PRIME:  if (cnt_zero) state_d = ST_SETTLE;
        ST_SETTLE: if (cnt_zero) state_d = ST_RUN;
        ST_RUN:    if (cfg_acc) state_d = ST_RETUNE;
        ST_RETUNE: if (cnt_zero) state_d = ST_RUN;
        ST_FLUSH:  state_d = ST_FILL;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Load the settle counter on entry to each timed state.
  always_comb begin
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    if (state_d != state_q) begin
      case (state_d)
        ST_PRIME:  begin cnt_load = 1'b1; cnt_load_val = PRIME_LD;  end
        ST_SETTLE: begin cnt_load = 1'b1; cnt_load_val = SETTLE_LD; end
        ST_RETUNE: begin cnt_load = 1'b1; cnt_load_val = RETUNE_LD; end
        default:   begin cnt_load = 1'b0; cnt_load_val = '0;        end
      endcase
    end
  end

  // State register plus registered outputs decoded from the next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      rd_en_q     <= 1'b0;
      flush_q     <= 1'b0;
      osc_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      pinc_q      <= '0;
      pinc_load_q <= 1'b0;
      pend_q      <= '0;
      pend_vld_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_q     <= 1'b0;
      pinc_load_q <= 1'b0;
      // Accepted values park here unless the entry below applies them now.
      if (cfg_acc) begin
        pend_q     <= cfg.cfg_pinc_i;
        pend_vld_q <= 1'b1;
      end
      unique case (state_d)
        ST_PRIME: begin
          rd_en_q     <= 1'b1;
          osc_valid_q <= 1'b1;
          out_valid_q <= 1'b0;
          if (state_q != ST_PRIME) begin
            if (cfg_acc) begin
              pinc_q      <= cfg.cfg_pinc_i;
              pinc_load_q <= 1'b1;
              pend_vld_q  <= 1'b0;
            end else if (pend_vld_q) begin
              pinc_q      <= pend_q;
              pinc_load_q <= 1'b1;
              pend_vld_q  <= 1'b0;
            end
          end
        end
        ST_SETTLE: begin
          rd_en_q     <= 1'b1;
          osc_valid_q <= 1'b1;
          out_valid_q <= 1'b0;
        end
        ST_RUN: begin
          rd_en_q     <= 1'b1;
          osc_valid_q <= 1'b1;
          out_valid_q <= 1'b1;
        end
        ST_RETUNE: begin
          rd_en_q     <= 1'b1;
          osc_valid_q <= 1'b1;
          out_valid_q <= 1'b0;
          // RETUNE is only entered from RUN on an accepted config.
          if (state_q != ST_RETUNE) begin
            pinc_q      <= cfg.cfg_pinc_i;
            pinc_load_q <= 1'b1;
            pend_vld_q  <= 1'b0;
          end
        end
        ST_FLUSH: begin
          rd_en_q     <= 1'b0;
          osc_valid_q <= 1'b0;
          out_valid_q <= 1'b0;
          flush_q     <= 1'b1;
        end
        default: begin
          rd_en_q     <= 1'b0;
          osc_valid_q <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign cfg.cfg_ready_o = cfg_ready;
  assign fifo_rd_en_o    = rd_en_q;
  assign fifo_flush_o    = flush_q;
  assign osc_valid_o     = osc_valid_q;
  assign out_valid_o     = out_valid_q;
  assign pinc_o          = pinc_q;
  assign pinc_load_o     = pinc_load_q;
  assign state_o         = state_q;

endmodule
